// File: rtl/rename_pkg.sv
// Shared types and default sizing for the multi-lane register renamer.
// Lane structs bundle one rename or commit slot at the default widths.
package rename_pkg;
    localparam int ARCH_REGS_DEF = 32;
    localparam int PHYS_REGS_DEF = 64;
    localparam int W_DEF         = 2;
    localparam int ARCH_W        = $clog2(ARCH_REGS_DEF);
    localparam int PHYS_W        = $clog2(PHYS_REGS_DEF);

    typedef logic [ARCH_W-1:0] arch_reg_t;
    typedef logic [PHYS_W-1:0] phys_reg_t;

    typedef struct packed {
        logic      valid;
        logic      has_dst;
        arch_reg_t src1;
        arch_reg_t src2;
        arch_reg_t dst;
    } rename_lane_t;

    typedef struct packed {
        logic      valid;
        arch_reg_t arch_dst;
        phys_reg_t phys_dst;
        phys_reg_t old_phys_dst;
    } commit_lane_t;
endpackage

// File: rtl/free_reg_picker.sv
// Free bit vector -> lowest W set indices, lowest first, plus per-slot found flags.
// Purely combinational, no backpressure.
module free_reg_picker #(
    parameter int N = 64,
    parameter int W = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]    free_vec,
    output logic [W*PW-1:0] pick_idx,
    output logic [W-1:0]    pick_found
);
    logic [N-1:0]  mask;
    logic [PW-1:0] sel;
    logic          hit;

    always_comb begin
        mask       = free_vec;
        pick_idx   = '0;
        pick_found = '0;
        sel        = '0;
        hit        = 1'b0;
        for (int k = 0; k < W; k++) begin
            sel = '0;
            hit = 1'b0;
            // Scan downward so the last hit is the lowest index.
            for (int p = N - 1; p >= 0; p--) begin
                if (mask[p]) begin
                    sel = PW'(p);
                    hit = 1'b1;
                end
            end
            if (hit) mask[sel] = 1'b0;
            pick_idx[k*PW +: PW] = sel;
            pick_found[k]        = hit;
        end
    end
endmodule

// File: rtl/rename_unit_mw.sv
// W-lane register renamer: speculative RAT, retirement RRAT, free-phys vector, flush restore.
// Lookups 0-cycle, state updates at posedge; group stalls whole while fewer than W regs free or on flush.
module rename_unit_mw
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PHYS_REGS = PHYS_REGS_DEF,
    parameter int W         = W_DEF,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(PHYS_REGS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    rn_valid,
    input  logic [W-1:0]    rn_has_dst,
    input  logic [W*AW-1:0] rn_arch_src1,
    input  logic [W*AW-1:0] rn_arch_src2,
    input  logic [W*AW-1:0] rn_arch_dst,
    output logic            rn_ready,
    output logic [W*PW-1:0] rn_phys_src1,
    output logic [W*PW-1:0] rn_phys_src2,
    output logic [W*PW-1:0] rn_phys_dst,
    output logic [W*PW-1:0] rn_old_phys_dst,
    input  logic [W-1:0]    cm_valid,
    input  logic [W*AW-1:0] cm_arch_dst,
    input  logic [W*PW-1:0] cm_phys_dst,
    input  logic [W*PW-1:0] cm_old_phys_dst,
    input  logic            flush,
    output logic [CW-1:0]   free_count
);
    logic [PW-1:0]        rat      [ARCH_REGS];
    logic [PW-1:0]        rrat     [ARCH_REGS];
    logic [PW-1:0]        rrat_nxt [ARCH_REGS];
    logic [PHYS_REGS-1:0] free_vec, free_vec_nxt, free_set, alloc_mask, flush_free;
    logic [CW-1:0]        free_cnt, free_cnt_nxt, flush_cnt, alloc_cnt;

    logic [W*PW-1:0] pick_idx;
    logic [W-1:0]    pick_found;
    logic [PW-1:0]   pick     [W];
    logic [AW-1:0]   dst_a    [W];
    logic [PW-1:0]   new_phys [W];
    logic [W-1:0]    need;
    logic            accept;

    logic [AW-1:0] a1, a2;
    logic [PW-1:0] s1, s2, od;

    free_reg_picker #(.N(PHYS_REGS), .W(W)) u_picker (
        .free_vec   (free_vec),
        .pick_idx   (pick_idx),
        .pick_found (pick_found)
    );

    for (genvar k = 0; k < W; k++) begin : g_pick
        assign pick[k] = pick_idx[k*PW +: PW];
    end

    assign rn_ready   = (free_cnt >= CW'(W)) & ~flush;
    assign accept     = rn_ready & (|rn_valid);
    assign free_count = free_cnt;

    // Allocating lanes take picker slots in lane order.
    always_comb begin
        int ord;
        ord        = 0;
        need       = '0;
        alloc_mask = '0;
        alloc_cnt  = '0;
        for (int k = 0; k < W; k++) begin
            dst_a[k]    = rn_arch_dst[k*AW +: AW];
            new_phys[k] = '0;
            need[k]     = rn_valid[k] & rn_has_dst[k] & (dst_a[k] != '0);
            if (need[k]) begin
                for (int m = 0; m < W; m++)
                    if (m == ord && pick_found[m]) new_phys[k] = pick[m];
                ord++;
            end
            if (accept && need[k]) begin
                alloc_mask[new_phys[k]] = 1'b1;
                alloc_cnt               = alloc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rn_phys_src1    = '0;
        rn_phys_src2    = '0;
        rn_phys_dst     = '0;
        rn_old_phys_dst = '0;
        a1 = '0;
        a2 = '0;
        s1 = '0;
        s2 = '0;
        od = '0;
        for (int k = 0; k < W; k++) begin
            a1 = rn_arch_src1[k*AW +: AW];
            a2 = rn_arch_src2[k*AW +: AW];
            s1 = rat[a1];
            s2 = rat[a2];
            od = rat[dst_a[k]];
            // Later j overrides earlier: newest older writer in the group wins.
            for (int j = 0; j < k; j++) begin
                if (need[j] && dst_a[j] == a1)       s1 = new_phys[j];
                if (need[j] && dst_a[j] == a2)       s2 = new_phys[j];
                if (need[j] && dst_a[j] == dst_a[k]) od = new_phys[j];
            end
            if (a1 == '0) s1 = '0;
            if (a2 == '0) s2 = '0;
            if (!need[k]) od = '0;
            if (reset && rn_ready && rn_valid[k]) begin
                rn_phys_src1[k*PW +: PW]    = s1;
                rn_phys_src2[k*PW +: PW]    = s2;
                rn_phys_dst[k*PW +: PW]     = new_phys[k];
                rn_old_phys_dst[k*PW +: PW] = od;
            end
        end
    end

    always_comb begin
        rrat_nxt = rrat;
        free_set = '0;
        for (int k = 0; k < W; k++) begin
            if (cm_valid[k] && cm_arch_dst[k*AW +: AW] != '0) begin
                rrat_nxt[cm_arch_dst[k*AW +: AW]] = cm_phys_dst[k*PW +: PW];
                if (cm_old_phys_dst[k*PW +: PW] != '0 && !free_vec[cm_old_phys_dst[k*PW +: PW]])
                    free_set[cm_old_phys_dst[k*PW +: PW]] = 1'b1;
            end
        end
    end

    // After flush, everything not held by the retirement map is free.
    always_comb begin
        flush_free    = '1;
        flush_free[0] = 1'b0;
        for (int a = 0; a < ARCH_REGS; a++) flush_free[rrat_nxt[a]] = 1'b0;
    end

    assign free_vec_nxt = (free_vec & ~alloc_mask) | free_set;
    assign free_cnt_nxt = free_cnt - alloc_cnt + CW'($countones(free_set));
    assign flush_cnt    = CW'($countones(flush_free));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                rat[a]  <= PW'(a);
                rrat[a] <= PW'(a);
            end
            free_vec <= {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
            free_cnt <= CW'(PHYS_REGS - ARCH_REGS);
        end else begin
            for (int a = 0; a < ARCH_REGS; a++) rrat[a] <= rrat_nxt[a];
            if (flush) begin
                for (int a = 0; a < ARCH_REGS; a++) rat[a] <= rrat_nxt[a];
                free_vec <= flush_free;
                free_cnt <= flush_cnt;
            end else begin
                if (accept)
                    for (int k = 0; k < W; k++)
                        if (need[k]) rat[dst_a[k]] <= new_phys[k];
                free_vec <= free_vec_nxt;
                free_cnt <= free_cnt_nxt;
            end
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_free_chk
        assert property (@(posedge clk) disable iff (!reset)
            (cm_valid[k] && cm_arch_dst[k*AW +: AW] != '0) |->
                (cm_old_phys_dst[k*PW +: PW] != '0 && !free_vec[cm_old_phys_dst[k*PW +: PW]]));
    end
endmodule
